// File: rtl/br_pkg.sv
// Shared types and constants for the branch resolution controller.
package br_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef enum logic {RUN, FLUSH} br_state_t;

  typedef enum logic [1:0] {K_BR, K_JAL, K_JALR} br_kind_t;

  // funct3 values 010/011 have no comparator decode, so they can never be taken.
  function automatic logic br_type_legal(input logic [2:0] t);
    return t[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch/jump resolution for the 3-stage core: static not-taken, redirect plus
// a multi-cycle flush on every taken branch or jump.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_is_branch,
  input  logic            id_is_jal,
  input  logic            id_is_jalr,
  input  logic [2:0]      id_br_type,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1,
  input  logic            stall,
  input  logic            br_taken,
  output logic [2:0]      br_type,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] redir_count
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  logic            ex_valid;
  br_kind_t        ex_kind;
  logic [2:0]      ex_br_type;
  logic [XLEN-1:0] ex_target;

  br_state_t state, state_next;
  logic [2:0] fcnt, fcnt_next;

  logic            taken;
  logic            redirect_req;
  logic            flush_int;
  logic            capture;
  logic [XLEN-1:0] jalr_sum;

  assign taken = (ex_kind == K_JAL) || (ex_kind == K_JALR) ||
                 ((ex_kind == K_BR) && br_taken && br_type_legal(ex_br_type));

  assign redirect_req = ex_valid && taken && !stall && (state == RUN);
  assign flush_int    = (state == FLUSH) || redirect_req;

  // A redirect in EX makes the ID instruction wrong-path, so flush also blocks capture.
  assign capture  = id_valid && (id_is_branch || id_is_jal || id_is_jalr) && !stall && !flush_int;
  assign jalr_sum = id_rs1 + id_imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_kind    <= K_BR;
      ex_br_type <= '0;
      ex_target  <= '0;
    end else if (!stall) begin
      ex_valid <= capture;
      if (capture) begin
        ex_br_type <= id_br_type;
        if (id_is_jal) begin
          ex_kind   <= K_JAL;
          ex_target <= id_pc + id_imm;
        end else if (id_is_jalr) begin
          ex_kind   <= K_JALR;
          ex_target <= {jalr_sum[XLEN-1:1], 1'b0};
        end else begin
          ex_kind   <= K_BR;
          ex_target <= id_pc + id_imm;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      RUN: begin
        if (redirect_req && (FLUSH_CYCLES > 1)) begin
          state_next = FLUSH;
          fcnt_next  = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (!stall) begin
          fcnt_next = fcnt - 3'd1;
          if (fcnt == 3'd1)
            state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        fcnt_next  = '0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held, whatever the slot contains.
  always_comb begin
    redirect    = redirect_req && !rst;
    flush       = flush_int && !rst;
    br_type     = (ex_valid && (ex_kind == K_BR) && !rst) ? ex_br_type : 3'b000;
    redirect_pc = rst ? '0 : ex_target;
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (!stall && ex_valid && (ex_kind == K_BR)),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirect_req),
    .count (redir_count)
  );

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: two instances (2-cycle flush / 32-bit counters and
// 4-cycle flush / 4-bit counters) checked every cycle against a behavioural model.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_branch, id_is_jal, id_is_jalr;
  logic [2:0]  id_br_type;
  logic [31:0] id_pc, id_imm, id_rs1;
  logic        stall, br_taken;

  logic [2:0]  br_type0, br_type1;
  logic        redirect0, redirect1, flush0, flush1;
  logic [31:0] redirect_pc0, redirect_pc1;
  logic [31:0] br_count0, redir_count0;
  logic [3:0]  br_count1, redir_count1;

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  branch_ctrl dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_br_type(id_br_type),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .stall(stall),
    .br_taken(br_taken), .br_type(br_type0), .redirect(redirect0),
    .redirect_pc(redirect_pc0), .flush(flush0), .br_count(br_count0),
    .redir_count(redir_count0)
  );

  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(4), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_br_type(id_br_type),
    .id_pc(id_pc), .id_imm(id_imm), .id_rs1(id_rs1), .stall(stall),
    .br_taken(br_taken), .br_type(br_type1), .redirect(redirect1),
    .redirect_pc(redirect_pc1), .flush(flush1), .br_count(br_count1),
    .redir_count(redir_count1)
  );

  // kind: 0 branch, 1 jal, 2 jalr; flush_left counts flush cycles still owed after a redirect.
  typedef struct {
    bit        valid;
    int        kind;
    bit [2:0]  btype;
    bit [31:0] target;
    int        flush_left;
    longint    br_cnt;
    longint    redir_cnt;
  } model_t;

  model_t mdl[2];
  int     fcyc[2] = '{2, 4};
  longint cmax[2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
  int     cur_kind;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
  endtask

  function automatic bit exp_redirect(input int m);
    bit tk;
    tk = mdl[m].valid &&
         (mdl[m].kind != 0 || (br_taken && !(mdl[m].btype inside {3'b010, 3'b011})));
    return !rst && tk && !stall && (mdl[m].flush_left == 0);
  endfunction

  function automatic bit exp_flush(input int m);
    return !rst && (exp_redirect(m) || mdl[m].flush_left > 0);
  endfunction

  function automatic logic [2:0] exp_br_type(input int m);
    return (!rst && mdl[m].valid && mdl[m].kind == 0) ? mdl[m].btype : 3'b000;
  endfunction

  task automatic model_reset(input int m);
    mdl[m].valid      = 1'b0;
    mdl[m].kind       = 0;
    mdl[m].btype      = '0;
    mdl[m].target     = '0;
    mdl[m].flush_left = 0;
    mdl[m].br_cnt     = 0;
    mdl[m].redir_cnt  = 0;
  endtask

  task automatic model_step(input int m);
    bit red, fl, cap;
    if (rst) begin
      model_reset(m);
      return;
    end
    red = exp_redirect(m);
    fl  = red || mdl[m].flush_left > 0;
    cap = id_valid && cur_kind != 0 && !stall && !fl;
    if (!stall && mdl[m].valid && mdl[m].kind == 0 && mdl[m].br_cnt < cmax[m])
      mdl[m].br_cnt++;
    if (red && mdl[m].redir_cnt < cmax[m])
      mdl[m].redir_cnt++;
    if (red)
      mdl[m].flush_left = fcyc[m] - 1;
    else if (mdl[m].flush_left > 0 && !stall)
      mdl[m].flush_left--;
    if (!stall) begin
      mdl[m].valid = cap;
      if (cap) begin
        mdl[m].kind  = cur_kind - 1;
        mdl[m].btype = id_br_type;
        if (cur_kind == 3)
          mdl[m].target = (id_rs1 + id_imm) & ~32'd1;
        else
          mdl[m].target = id_pc + id_imm;
      end
    end
  endtask

  // kindsel: 0 none, 1 branch, 2 jal, 3 jalr. Checks this cycle's outputs, then advances the model.
  task automatic applyStimulus(input bit r, input bit v, input int kindsel, input logic [2:0] bt,
                               input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                               input bit st, input bit tk);
    @(negedge clk);
    rst          = r;
    id_valid     = v;
    cur_kind     = kindsel;
    id_is_branch = (kindsel == 1);
    id_is_jal    = (kindsel == 2);
    id_is_jalr   = (kindsel == 3);
    id_br_type   = bt;
    id_pc        = pc;
    id_imm       = imm;
    id_rs1       = rs1;
    stall        = st;
    br_taken     = tk;
    #1;
    checkOutput("redirect0", redirect0, exp_redirect(0));
    checkOutput("flush0", flush0, exp_flush(0));
    checkOutput("br_type0", br_type0, exp_br_type(0));
    checkOutput("redirect_pc0", redirect_pc0, rst ? 32'd0 : mdl[0].target);
    checkOutput("br_count0", br_count0, mdl[0].br_cnt);
    checkOutput("redir_count0", redir_count0, mdl[0].redir_cnt);
    checkOutput("redirect1", redirect1, exp_redirect(1));
    checkOutput("flush1", flush1, exp_flush(1));
    checkOutput("br_type1", br_type1, exp_br_type(1));
    checkOutput("redirect_pc1", redirect_pc1, rst ? 32'd0 : mdl[1].target);
    checkOutput("br_count1", br_count1, mdl[1].br_cnt);
    checkOutput("redir_count1", redir_count1, mdl[1].redir_cnt);
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input bit tk);
    applyStimulus(0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, tk);
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_is_branch = 0; id_is_jal = 0; id_is_jalr = 0;
    id_br_type = '0; id_pc = '0; id_imm = '0; id_rs1 = '0; stall = 0; br_taken = 0;
    cur_kind = 0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);

    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 0);

    // Taken BEQ: 0x100 + 0x20, two flush cycles on the default instance.
    applyStimulus(0, 1, 1, 3'b000, 32'h100, 32'h20, 32'h0, 0, 0);
    idle(1);
    checkOutput("beq_redirect", redirect0, 1'b1);
    checkOutput("beq_target", redirect_pc0, 32'h120);
    checkOutput("beq_flush_a", flush0, 1'b1);
    idle(1);
    checkOutput("beq_flush_b", flush0, 1'b1);
    idle(0);
    checkOutput("beq_flush_end", flush0, 1'b0);
    checkOutput("beq_redir_cnt", redir_count0, 32'd1);
    checkOutput("beq_br_cnt", br_count0, 32'd1);

    // Not-taken BNE.
    applyStimulus(0, 1, 1, 3'b001, 32'h200, 32'h40, 32'h0, 0, 0);
    idle(0);
    checkOutput("bne_type", br_type0, 3'b001);
    checkOutput("bne_redirect", redirect0, 1'b0);
    checkOutput("bne_flush", flush0, 1'b0);
    idle(0);
    checkOutput("bne_br_cnt", br_count0, 32'd2);
    checkOutput("bne_redir_cnt", redir_count0, 32'd1);

    // jalr clears bit 0 and redirects regardless of br_taken.
    applyStimulus(0, 1, 3, 3'b000, 32'h300, 32'h10, 32'h2001, 0, 0);
    idle(0);
    checkOutput("jalr_redirect", redirect0, 1'b1);
    checkOutput("jalr_target", redirect_pc0, 32'h2010);
    idle(0);
    idle(0);
    checkOutput("jalr_br_cnt", br_count0, 32'd2);

    // Taken branch in EX while another branch waits in ID.
    applyStimulus(0, 1, 1, 3'b100, 32'h400, 32'h8, 32'h0, 0, 0);
    applyStimulus(0, 1, 1, 3'b000, 32'h404, 32'h80, 32'h0, 0, 1);
    checkOutput("shadow_redirect", redirect0, 1'b1);
    idle(1);
    idle(1);
    checkOutput("shadow_no_redirect", redirect0, 1'b0);
    idle(1);
    checkOutput("shadow_no_redirect2", redirect0, 1'b0);
    repeat (3) idle(0);

    // Taken BLT held by stall, then a stall inside FLUSH.
    applyStimulus(0, 1, 1, 3'b100, 32'h500, 32'hFFFF_FFF0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
      checkOutput("stall_no_redirect", redirect0, 1'b0);
    end
    idle(1);
    checkOutput("stall_release_redirect", redirect0, 1'b1);
    checkOutput("stall_target", redirect_pc0, 32'h4F0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 3'b000, 0, 0, 0, 1, 1);
      checkOutput("flush_stalled", flush0, 1'b1);
    end
    idle(1);
    checkOutput("flush_last", flush0, 1'b1);
    idle(1);
    checkOutput("flush_done", flush0, 1'b0);
    repeat (4) idle(0);

    // Reset in the first FLUSH cycle of the 4-cycle instance.
    applyStimulus(0, 1, 2, 3'b000, 32'h600, 32'h100, 32'h0, 0, 0);
    idle(0);
    checkOutput("rstf_redirect", redirect1, 1'b1);
    applyStimulus(1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    idle(0);
    checkOutput("rstf_flush", flush1, 1'b0);
    checkOutput("rstf_br_cnt", br_count1, 4'd0);
    checkOutput("rstf_redir_cnt", redir_count1, 4'd0);
    checkOutput("rstf_br_type", br_type1, 3'b000);

    // Illegal funct3 010 with br_taken=1.
    applyStimulus(0, 1, 1, 3'b010, 32'h700, 32'h40, 32'h0, 0, 0);
    idle(1);
    checkOutput("illegal_redirect", redirect0, 1'b0);
    idle(1);
    checkOutput("illegal_br_cnt", br_count0, 32'd1);

    // Random traffic; rare resets let the 4-bit counters reach saturation.
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3), 3'($urandom_range(0, 7)),
                    $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch/jump resolution controller for the 3-stage pipelined core (IF, ID, EX).
- Captures branch, jal and jalr instructions from ID into an EX slot.
- Drives br_type to the combinational branch comparator and consumes br_taken.
- Uses a static not-taken prediction: every taken branch or jump redirects the PC and flushes the wrong-path IF/ID instructions for FLUSH_CYCLES cycles.
- Keeps saturating resolution/redirect counters for the CSR block.

Parameters:
XLEN, 32, datapath/PC width
FLUSH_CYCLES, 2, cycles flush stays high per redirect (legal range 1..7)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  core clock
rst  in  1  reset
id_valid  in  1  ID holds a valid instruction
id_is_branch  in  1  ID instruction is conditional branch
id_is_jal  in  1  ID instruction is jal
id_is_jalr  in  1  ID instruction is jalr
id_br_type  in  3  funct3 of ID branch
id_pc  in  XLEN  PC of ID instruction
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  XLEN  forwarded rs1 value (jalr base)
stall  in  1  hazard unit freeze of ID/EX
br_taken  in  1  comparator result for current br_type
br_type  out  3  to comparator
redirect  out  1  load redirect_pc into PC this cycle
redirect_pc  out  XLEN  target PC
flush  out  1  kill IF/ID contents
br_count  out  CNT_W  resolved conditional branches
redir_count  out  CNT_W  redirects issued

Behaviour:
- Reset: clk rising edge, rst synchronous, active-high. It clears the EX slot, state=RUN, flush counter=0 and both counters=0. Outputs during and after reset: redirect=0, flush=0, br_type=000, redirect_pc=0.
- EX slot registers: ex_valid, ex_kind (BR/JAL/JALR), ex_br_type, ex_target.
- Capture occurs when id_valid & (is_branch|is_jal|is_jalr) & !stall & !flush.
  - Branch and jal targets: ex_target = id_pc + id_imm, modulo 2^XLEN.
  - jalr target: ex_target = (id_rs1 + id_imm) & ~1.
- Any non-stalled cycle with no capture clears ex_valid. When stall=1, the EX slot holds unchanged.
- br_type = ex_br_type when ex_valid & ex_kind==BR; otherwise 000.
- Resolution happens in the EX cycle and is combinational.
  - taken = JAL | JALR | (BR & br_taken & ex_br_type ∉ {010,011}).
  - Illegal br_type values 010 and 011 are forced not-taken. The comparator has no default case for them.
- redirect = ex_valid & taken & !stall & state==RUN.
- redirect_pc = ex_target at all times.
- FSM, two states:
  - RUN: flush = redirect. On redirect with FLUSH_CYCLES>1, go to FLUSH with fcnt = FLUSH_CYCLES-1.
  - FLUSH: flush=1 and no capture. fcnt decrements on each non-stalled cycle; exit to RUN when it decrements from 1.
  - stall freezes fcnt but flush stays high.
- Same-cycle redirect in EX and branch in ID: the ID instruction is wrong-path and is not captured, so ex_valid clears.
- br_count increments on each non-stalled EX cycle with ex_valid & BR. This includes illegal br_type values.
- redir_count increments on each redirect.
- Both counters saturate at all-ones.
- Latency: capture, then resolve one cycle later. PC load on the next edge after redirect.
- Reset mid-FLUSH: return to RUN immediately and drop flush on the next cycle. Counters clear.

Decomposition:
- Package br_pkg holds:
  - br_type constants BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - typedef enum {RUN, FLUSH} br_state_t.
  - typedef enum {K_BR, K_JAL, K_JALR} br_kind_t.
- Sub-module sat_counter (parameter W; ports inc and clr) instantiated twice.

Test Plan:
- Take a BEQ capture at id_pc=0x100, imm=0x20, with br_taken=1 in EX. Required: redirect=1, redirect_pc=0x120, flush high exactly 2 cycles, redir_count=1, br_count=1.
- Take a BNE with br_taken=0. Required: redirect=0, flush=0, br_count=1, redir_count=0, br_type=001 during the EX cycle.
- Take a jalr with id_rs1=0x2001 and imm=0x10. Required: redirect_pc=0x2010, redirect=1 regardless of br_taken, br_count unchanged.
- Take a branch in EX with taken=1 and a second branch in ID in the same cycle. Required: the second branch is not captured, and no redirect occurs in the following cycles.
- Hold stall=1 for 3 cycles with a taken BLT in EX, then release. Required: redirect=0 while stalled and exactly one redirect after release. In a second case, stall during FLUSH extends flush by the stalled cycles.
- Assert rst in the first FLUSH cycle with FLUSH_CYCLES=4. Required: the next cycle has flush=0, counters=0 and br_type=000. Separately, ex_br_type=010 with br_taken=1 must give no redirect and br_count+1.
